// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared pipeline widths, control-word layout and edge-action helper
package id_ex_stage_pkg;

  localparam int NBITS = 32;
  localparam int RBITS = 5;
  localparam int CBITS = 21;

  // Control-word bit positions, MSB first
  localparam int REG_WRITE_BIT  = 20;
  localparam int ALU_SOURCE_BIT = 19;
  localparam int MEM_WRITE_BIT  = 18;
  localparam int ALU_OP_LSB     = 15;
  localparam int DATA_TO_REG_LSB = 13;
  localparam int MEM_READ_BIT   = 12;
  localparam int BEQ_BIT        = 11;
  localparam int BNE_BIT        = 10;
  localparam int JUMP_BIT       = 9;
  localparam int REG_DST_LSB    = 7;
  localparam int SELECT_ADDR_LSB = 5;
  localparam int SIZE_CONTROL_LSB = 0;

  typedef enum logic [1:0] {
    OP_LOAD,
    OP_HOLD,
    OP_BUBBLE,
    OP_RESET
  } edge_op_e;

  function automatic edge_op_e next_op(input logic reset, input logic enable,
                                       input logic flush, input logic stall);
    if (reset)
      return OP_RESET;
    else if (!enable)
      return OP_HOLD;
    else if (flush || stall)
      return OP_BUBBLE;
    else
      return OP_LOAD;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID-side inputs and EX-side registered outputs of the ID/EX stage
interface id_ex_stage_if
  import id_ex_stage_pkg::*;
  #(parameter int NB = NBITS, parameter int RB = RBITS, parameter int CB = CBITS);

  logic          i_enable;
  logic          i_flush;
  logic [CB-1:0] i_ctrl;
  logic [NB-1:0] i_pc4;
  logic [NB-1:0] i_rs_data;
  logic [NB-1:0] i_rt_data;
  logic [NB-1:0] i_imm;
  logic [RB-1:0] i_rs;
  logic [RB-1:0] i_rt;
  logic [RB-1:0] i_rd;
  logic [4:0]    i_shamt;

  logic [CB-1:0] o_ctrl;
  logic [NB-1:0] o_pc4;
  logic [NB-1:0] o_rs_data;
  logic [NB-1:0] o_rt_data;
  logic [NB-1:0] o_imm;
  logic [RB-1:0] o_rs;
  logic [RB-1:0] o_rt;
  logic [RB-1:0] o_rd;
  logic [4:0]    o_shamt;
  logic          o_valid;
  logic          o_stall;

  modport master (
    output i_enable, i_flush, i_ctrl, i_pc4, i_rs_data, i_rt_data, i_imm,
           i_rs, i_rt, i_rd, i_shamt,
    input  o_ctrl, o_pc4, o_rs_data, o_rt_data, o_imm, o_rs, o_rt, o_rd,
           o_shamt, o_valid, o_stall
  );

  modport slave (
    input  i_enable, i_flush, i_ctrl, i_pc4, i_rs_data, i_rt_data, i_imm,
           i_rs, i_rt, i_rd, i_shamt,
    output o_ctrl, o_pc4, o_rs_data, o_rt_data, o_imm, o_rs, o_rt, o_rd,
           o_shamt, o_valid, o_stall
  );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// rtl/id_ex_stage_hazard_detect.sv - load-use hazard between the load in EX and the ID sources
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [RBITS-1:0] ex_rt,
  input  logic [RBITS-1:0] id_rs,
  input  logic [RBITS-1:0] id_rt,
  output logic             stall
);

  // Register 0 is hardwired to zero, so a load targeting it never creates a dependency
  assign stall = ex_valid && ex_mem_read && (ex_rt != '0) &&
                 ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register bank with flush, freeze and load-use bubble
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_reset,
  id_ex_stage_if.slave  bus
);

  logic stall;

  hazard_detect u_hazard (
    .ex_valid    (bus.o_valid),
    .ex_mem_read (bus.o_ctrl[MEM_READ_BIT]),
    .ex_rt       (bus.o_rt),
    .id_rs       (bus.i_rs),
    .id_rt       (bus.i_rt),
    .stall       (stall)
  );

  assign bus.o_stall = stall;

  // A bubble clears o_valid, so the hazard drops the next cycle and a stall lasts one cycle
  always_ff @(posedge i_clk) begin
    case (next_op(i_reset, bus.i_enable, bus.i_flush, stall))
      OP_LOAD: begin
        bus.o_ctrl    <= bus.i_ctrl;
        bus.o_pc4     <= bus.i_pc4;
        bus.o_rs_data <= bus.i_rs_data;
        bus.o_rt_data <= bus.i_rt_data;
        bus.o_imm     <= bus.i_imm;
        bus.o_rs      <= bus.i_rs;
        bus.o_rt      <= bus.i_rt;
        bus.o_rd      <= bus.i_rd;
        bus.o_shamt   <= bus.i_shamt;
        bus.o_valid   <= 1'b1;
      end
      OP_HOLD: begin
      end
      default: begin
        bus.o_ctrl    <= '0;
        bus.o_pc4     <= '0;
        bus.o_rs_data <= '0;
        bus.o_rt_data <= '0;
        bus.o_imm     <= '0;
        bus.o_rs      <= '0;
        bus.o_rt      <= '0;
        bus.o_rd      <= '0;
        bus.o_shamt   <= '0;
        bus.o_valid   <= 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam logic [CBITS-1:0] CTRL_ADD = 21'h104180;
  localparam logic [CBITS-1:0] CTRL_LW  = 21'h181000;

  logic i_clk;
  logic i_reset;
  int   vectors;
  int   miscompares;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic [CBITS-1:0] ctrl, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] rs_data, input logic [31:0] rt_data);
    bus.i_ctrl    = ctrl;
    bus.i_rs      = rs;
    bus.i_rt      = rt;
    bus.i_rd      = rd;
    bus.i_rs_data = rs_data;
    bus.i_rt_data = rt_data;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;

    // Reset held two cycles with nonzero, hazard-looking inputs
    i_reset       = 1'b1;
    bus.i_enable  = 1'b1;
    bus.i_flush   = 1'b0;
    bus.i_pc4     = 32'h0000_0104;
    bus.i_imm     = 32'h0000_0005;
    bus.i_shamt   = 5'd4;
    drive(CTRL_LW, 5'd8, 5'd8, 5'd8, 32'hdead, 32'hbeef);
    tick();
    tick();
    chk("rst_ctrl", bus.o_ctrl, 0);
    chk("rst_pc4", bus.o_pc4, 0);
    chk("rst_rs_data", bus.o_rs_data, 0);
    chk("rst_rt_data", bus.o_rt_data, 0);
    chk("rst_imm", bus.o_imm, 0);
    chk("rst_rs", bus.o_rs, 0);
    chk("rst_rt", bus.o_rt, 0);
    chk("rst_rd", bus.o_rd, 0);
    chk("rst_shamt", bus.o_shamt, 0);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_stall", bus.o_stall, 0);

    // Plain add load
    i_reset = 1'b0;
    drive(CTRL_ADD, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22);
    tick();
    chk("ld_rs_data", bus.o_rs_data, 32'h11);
    chk("ld_rt_data", bus.o_rt_data, 32'h22);
    chk("ld_rd", bus.o_rd, 3);
    chk("ld_valid", bus.o_valid, 1);
    chk("ld_ctrl", bus.o_ctrl, CTRL_ADD);
    chk("ld_pc4", bus.o_pc4, 32'h104);
    chk("ld_imm", bus.o_imm, 32'h5);
    chk("ld_shamt", bus.o_shamt, 4);
    chk("ld_stall", bus.o_stall, 0);

    // Load-use: lw rt=8 in EX, ID reads rs=8
    drive(CTRL_LW, 5'd9, 5'd8, 5'd0, 32'h0, 32'h0);
    tick();
    drive(CTRL_ADD, 5'd8, 5'd10, 5'd11, 32'h33, 32'h34);
    #1;
    chk("lu_stall_now", bus.o_stall, 1);
    tick();
    chk("lu_bubble_ctrl", bus.o_ctrl, 0);
    chk("lu_bubble_valid", bus.o_valid, 0);
    chk("lu_bubble_rs_data", bus.o_rs_data, 0);
    chk("lu_stall_cleared", bus.o_stall, 0);
    tick();
    chk("lu_reload_rs_data", bus.o_rs_data, 32'h33);
    chk("lu_reload_valid", bus.o_valid, 1);
    chk("lu_reload_ctrl", bus.o_ctrl, CTRL_ADD);

    // Zero register never stalls
    drive(CTRL_LW, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();
    drive(CTRL_ADD, 5'd0, 5'd0, 5'd12, 32'h44, 32'h45);
    #1;
    chk("zr_stall", bus.o_stall, 0);
    tick();
    chk("zr_rs_data", bus.o_rs_data, 32'h44);
    chk("zr_valid", bus.o_valid, 1);

    // Flush coinciding with a load-use stall gives one bubble
    drive(CTRL_LW, 5'd1, 5'd5, 5'd0, 32'h0, 32'h0);
    tick();
    drive(CTRL_ADD, 5'd5, 5'd6, 5'd13, 32'h55, 32'h56);
    bus.i_flush = 1'b1;
    #1;
    chk("fs_stall_now", bus.o_stall, 1);
    tick();
    chk("fs_bubble_valid", bus.o_valid, 0);
    chk("fs_bubble_ctrl", bus.o_ctrl, 0);
    chk("fs_stall_cleared", bus.o_stall, 0);
    bus.i_flush = 1'b0;
    drive(CTRL_ADD, 5'd5, 5'd6, 5'd14, 32'h66, 32'h67);
    tick();
    chk("fs_next_rs_data", bus.o_rs_data, 32'h66);
    chk("fs_next_valid", bus.o_valid, 1);

    // Freeze with a lw in EX: flush ignored, stall still evaluated from held state
    drive(CTRL_LW, 5'd1, 5'd7, 5'd0, 32'h70, 32'h71);
    tick();
    bus.i_enable = 1'b0;
    bus.i_flush  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(CTRL_ADD, 5'd7, 5'(k), 5'(k + 1), 32'h100 + k, 32'h200 + k);
      tick();
      chk("fz_ctrl", bus.o_ctrl, CTRL_LW);
      chk("fz_rt", bus.o_rt, 7);
      chk("fz_rs_data", bus.o_rs_data, 32'h70);
      chk("fz_valid", bus.o_valid, 1);
      chk("fz_stall", bus.o_stall, 1);
    end
    bus.i_enable = 1'b1;
    bus.i_flush  = 1'b0;
    drive(CTRL_ADD, 5'd1, 5'd2, 5'd15, 32'h77, 32'h78);
    #1;
    chk("fz_resume_stall", bus.o_stall, 0);
    tick();
    chk("fz_resume_rs_data", bus.o_rs_data, 32'h77);
    chk("fz_resume_rd", bus.o_rd, 15);
    chk("fz_resume_valid", bus.o_valid, 1);

    // Reset mid-stall, with the stage frozen
    drive(CTRL_LW, 5'd1, 5'd9, 5'd0, 32'h0, 32'h0);
    tick();
    drive(CTRL_ADD, 5'd9, 5'd2, 5'd16, 32'h88, 32'h89);
    #1;
    chk("rs_stall_before", bus.o_stall, 1);
    i_reset = 1'b1;
    bus.i_enable = 1'b0;
    tick();
    chk("rs_valid", bus.o_valid, 0);
    chk("rs_ctrl", bus.o_ctrl, 0);
    chk("rs_stall", bus.o_stall, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
